// File: rtl/umi_stream_pkg.sv
// umi_stream_pkg: UMI opcodes, cmd field positions and controller state encoding shared
// by umi_stream_ctrl and umi_stream_resp.
package umi_stream_pkg;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  localparam int unsigned CmdOpLsb   = 0;
  localparam int unsigned CmdOpMsb   = 4;
  localparam int unsigned CmdSizeLsb = 5;
  localparam int unsigned CmdSizeMsb = 7;
  localparam int unsigned CmdLenLsb  = 8;
  localparam int unsigned CmdLenMsb  = 15;
  localparam int unsigned CmdEomBit  = 22;
  localparam int unsigned CmdErrLsb  = 25;
  localparam int unsigned CmdErrMsb  = 26;

  localparam logic [1:0] ErrDeverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPush = 3'd1,
    StAck  = 3'd2,
    StPop  = 3'd3,
    StResp = 3'd4,
    StErr  = 3'd5
  } state_e;

  // Where a freshly accepted request goes; devicemode only matters for reads.
  function automatic state_e decode_req(input logic [4:0] opcode, input logic devicemode);
    state_e st;
    if (opcode == REQ_POSTED || opcode == REQ_WRITE) begin
      st = StPush;
    end else if (opcode == REQ_READ && devicemode) begin
      st = StPop;
    end else begin
      st = StErr;
    end
    return st;
  endfunction

endpackage

// File: rtl/umi_stream_resp.sv
// umi_stream_resp: combinational UMI response builder; swaps addresses and copies
// size/len/EOM from the captured request.
module umi_stream_resp
  import umi_stream_pkg::*;
#(
  parameter int unsigned AW = 64,
  parameter int unsigned CW = 32,
  parameter int unsigned DW = 256
) (
  input  logic          is_read_i,
  input  logic          deverr_i,
  input  logic [2:0]    req_size_i,
  input  logic [7:0]    req_len_i,
  input  logic          req_eom_i,
  input  logic [AW-1:0] req_dstaddr_i,
  input  logic [AW-1:0] req_srcaddr_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic          rd_last_i,
  output logic [CW-1:0] resp_cmd_o,
  output logic [AW-1:0] resp_dstaddr_o,
  output logic [AW-1:0] resp_srcaddr_o,
  output logic [DW-1:0] resp_data_o
);

  logic rd_ok;
  assign rd_ok = is_read_i & ~deverr_i;

  always_comb begin
    resp_cmd_o = '0;
    resp_cmd_o[CmdOpMsb:CmdOpLsb]     = is_read_i ? RESP_READ : RESP_WRITE;
    resp_cmd_o[CmdSizeMsb:CmdSizeLsb] = req_size_i;
    resp_cmd_o[CmdLenMsb:CmdLenLsb]   = req_len_i;
    // A good read reports the popped beat's last flag; everything else echoes the request.
    resp_cmd_o[CmdEomBit]             = rd_ok ? rd_last_i : req_eom_i;
    resp_cmd_o[CmdErrMsb:CmdErrLsb]   = deverr_i ? ErrDeverr : 2'b00;
  end

  assign resp_dstaddr_o = req_srcaddr_i;
  assign resp_srcaddr_o = req_dstaddr_i;
  assign resp_data_o    = rd_ok ? rd_data_i : '0;

endmodule

// File: rtl/umi_stream_ctrl.sv
// umi_stream_ctrl: bridges UMI requests to MM2S/S2MM stream fifos, one request in flight.
// Define UMI_STREAM_CTRL_STATS_EN to add stat_push/stat_pop/stat_err counters.
module umi_stream_ctrl
  import umi_stream_pkg::*;
#(
  parameter int unsigned AW = 64,
  parameter int unsigned CW = 32,
  parameter int unsigned DW = 256
) (
  input  logic          umi_clk,
  input  logic          umi_nreset,
  input  logic          devicemode,
  input  logic          umi_in_valid,
  output logic          umi_in_ready,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_out_valid,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  output logic          mm2s_valid,
  input  logic          mm2s_ready,
  output logic [DW-1:0] mm2s_data,
  output logic          mm2s_last,
  input  logic          s2mm_valid,
  output logic          s2mm_ready,
  input  logic [DW-1:0] s2mm_data,
  input  logic          s2mm_last,
  output logic          err_flag
`ifdef UMI_STREAM_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_push,
  output logic [31:0]   stat_pop,
  output logic [31:0]   stat_err
`endif
);

  state_e          state_q, state_d;
  logic [4:0]      op_q;
  logic [2:0]      size_q;
  logic [7:0]      len_q;
  logic            eom_q;
  logic [AW-1:0]   dst_q;
  logic [AW-1:0]   src_q;
  logic [DW-1:0]   data_q;
  logic            rlast_q;
  logic            err_flag_q;
  logic            active_q;
  logic            accept;
  logic            pop_hs;

  // Cmd bits the controller neither decodes nor echoes.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{umi_in_cmd[CW-1:CmdEomBit+1], umi_in_cmd[CmdEomBit-1:CmdLenMsb+1]};

  assign accept = umi_in_valid & umi_in_ready;
  assign pop_hs = s2mm_valid & s2mm_ready;

  always_comb begin
    state_d       = state_q;
    umi_in_ready  = 1'b0;
    mm2s_valid    = 1'b0;
    s2mm_ready    = 1'b0;
    umi_out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // active_q holds ready low until the first edge after reset release.
        umi_in_ready = active_q;
        if (umi_in_valid && active_q) begin
          state_d = decode_req(umi_in_cmd[CmdOpMsb:CmdOpLsb], devicemode);
        end
      end
      StPush: begin
        mm2s_valid = 1'b1;
        if (mm2s_ready) begin
          state_d = (op_q == REQ_WRITE) ? StAck : StIdle;
        end
      end
      StAck: begin
        umi_out_valid = 1'b1;
        if (umi_out_ready) state_d = StIdle;
      end
      StPop: begin
        s2mm_ready = s2mm_valid;
        if (s2mm_valid) state_d = StResp;
      end
      StResp: begin
        umi_out_valid = 1'b1;
        if (umi_out_ready) state_d = StIdle;
      end
      StErr: begin
        // Only a rejected read expects an answer; other illegal opcodes are dropped.
        if (op_q == REQ_READ) begin
          umi_out_valid = 1'b1;
          if (umi_out_ready) state_d = StIdle;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge umi_clk or negedge umi_nreset) begin
    if (!umi_nreset) begin
      state_q    <= StIdle;
      active_q   <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      if (state_d == StErr) err_flag_q <= 1'b1;
    end
  end

  always_ff @(posedge umi_clk or negedge umi_nreset) begin
    if (!umi_nreset) begin
      op_q    <= '0;
      size_q  <= '0;
      len_q   <= '0;
      eom_q   <= 1'b0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      rlast_q <= 1'b0;
    end else if (accept) begin
      op_q   <= umi_in_cmd[CmdOpMsb:CmdOpLsb];
      size_q <= umi_in_cmd[CmdSizeMsb:CmdSizeLsb];
      len_q  <= umi_in_cmd[CmdLenMsb:CmdLenLsb];
      eom_q  <= umi_in_cmd[CmdEomBit];
      dst_q  <= umi_in_dstaddr;
      src_q  <= umi_in_srcaddr;
      data_q <= umi_in_data;
    end else if (pop_hs) begin
      // Reads never push, so the payload register doubles as the popped-beat latch.
      data_q  <= s2mm_data;
      rlast_q <= s2mm_last;
    end
  end

  assign mm2s_data = data_q;
  assign mm2s_last = eom_q;
  assign err_flag  = err_flag_q;

  umi_stream_resp #(
    .AW (AW),
    .CW (CW),
    .DW (DW)
  ) u_resp (
    .is_read_i      (op_q == REQ_READ),
    .deverr_i       (state_q == StErr),
    .req_size_i     (size_q),
    .req_len_i      (len_q),
    .req_eom_i      (eom_q),
    .req_dstaddr_i  (dst_q),
    .req_srcaddr_i  (src_q),
    .rd_data_i      (data_q),
    .rd_last_i      (rlast_q),
    .resp_cmd_o     (umi_out_cmd),
    .resp_dstaddr_o (umi_out_dstaddr),
    .resp_srcaddr_o (umi_out_srcaddr),
    .resp_data_o    (umi_out_data)
  );

`ifdef UMI_STREAM_CTRL_STATS_EN
  logic push_hs;
  logic err_entry;
  assign push_hs   = mm2s_valid & mm2s_ready;
  assign err_entry = (state_q != StErr) && (state_d == StErr);

  always_ff @(posedge umi_clk or negedge umi_nreset) begin
    if (!umi_nreset) begin
      stat_push <= '0;
      stat_pop  <= '0;
      stat_err  <= '0;
    end else begin
      if (push_hs)   stat_push <= stat_push + 32'd1;
      if (pop_hs)    stat_pop  <= stat_pop + 32'd1;
      if (err_entry) stat_err  <= stat_err + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_umi_stream_ctrl.sv
// tb_umi_stream_ctrl: directed stimulus plus a queue-based transaction model checked
// on every falling edge.
module tb_umi_stream_ctrl;

  localparam int unsigned AW = 64;
  localparam int unsigned CW = 32;
  localparam int unsigned DW = 256;

  logic          umi_clk = 1'b0;
  logic          umi_nreset;
  logic          devicemode;
  logic          umi_in_valid;
  logic          umi_in_ready;
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr;
  logic [AW-1:0] umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;
  logic          umi_out_valid;
  logic          umi_out_ready;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          mm2s_valid;
  logic          mm2s_ready;
  logic [DW-1:0] mm2s_data;
  logic          mm2s_last;
  logic          s2mm_valid;
  logic          s2mm_ready;
  logic [DW-1:0] s2mm_data;
  logic          s2mm_last;
  logic          err_flag;
`ifdef UMI_STREAM_CTRL_STATS_EN
  logic [31:0]   stat_push;
  logic [31:0]   stat_pop;
  logic [31:0]   stat_err;
`endif

  umi_stream_ctrl #(
    .AW (AW),
    .CW (CW),
    .DW (DW)
  ) dut (
    .umi_clk         (umi_clk),
    .umi_nreset      (umi_nreset),
    .devicemode      (devicemode),
    .umi_in_valid    (umi_in_valid),
    .umi_in_ready    (umi_in_ready),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_out_valid   (umi_out_valid),
    .umi_out_ready   (umi_out_ready),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .mm2s_valid      (mm2s_valid),
    .mm2s_ready      (mm2s_ready),
    .mm2s_data       (mm2s_data),
    .mm2s_last       (mm2s_last),
    .s2mm_valid      (s2mm_valid),
    .s2mm_ready      (s2mm_ready),
    .s2mm_data       (s2mm_data),
    .s2mm_last       (s2mm_last),
    .err_flag        (err_flag)
`ifdef UMI_STREAM_CTRL_STATS_EN
    ,
    .stat_push       (stat_push),
    .stat_pop        (stat_pop),
    .stat_err        (stat_err)
`endif
  );

  always #5 umi_clk = ~umi_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Cmd word from its fields: err[26:25], eom[22], len[15:8], size[7:5], opcode[4:0].
  function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input logic [2:0] sz,
                                           input logic [7:0] ln, input logic eom,
                                           input logic [1:0] err);
    return {5'b0, err, 2'b0, eom, 6'b0, ln, sz, op};
  endfunction

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } resp_t;

  // Transaction model: what each accepted request must eventually produce.
  logic [DW:0] beat_q[$];
  resp_t       resp_q[$];
  resp_t       rd_pend[$];
  logic        err_exp;

  logic          p_mv, p_mr, p_mlast, p_ov, p_or;
  logic [DW-1:0] p_mdata, p_odata;
  logic [CW-1:0] p_ocmd;
  logic [AW-1:0] p_odst, p_osrc;

  always @(negedge umi_clk) begin
    if (!umi_nreset) begin
      beat_q.delete();
      resp_q.delete();
      rd_pend.delete();
      err_exp = 1'b0;
      p_mv    = 1'b0;
      p_ov    = 1'b0;
    end else begin
      chk("err_flag_model", err_flag, err_exp);
      if (p_mv && !p_mr) begin
        chk("mm2s_valid_held", mm2s_valid, 1'b1);
        chk("mm2s_data_stable", mm2s_data, p_mdata);
        chk("mm2s_last_stable", mm2s_last, p_mlast);
      end
      if (p_ov && !p_or) begin
        chk("out_valid_held", umi_out_valid, 1'b1);
        chk("out_cmd_stable", umi_out_cmd, p_ocmd);
        chk("out_dst_stable", umi_out_dstaddr, p_odst);
        chk("out_src_stable", umi_out_srcaddr, p_osrc);
        chk("out_data_stable", umi_out_data, p_odata);
      end
      if (mm2s_valid && mm2s_ready) begin
        chk("mm2s_beat_expected", beat_q.size() != 0, 1'b1);
        if (beat_q.size() != 0) begin
          chk("mm2s_data", mm2s_data, beat_q[0][DW-1:0]);
          chk("mm2s_last", mm2s_last, beat_q[0][DW]);
          void'(beat_q.pop_front());
        end
      end
      if (s2mm_ready) chk("s2mm_ready_only_with_valid", s2mm_valid, 1'b1);
      if (s2mm_valid && s2mm_ready) begin
        chk("s2mm_pop_expected", rd_pend.size() != 0, 1'b1);
        if (rd_pend.size() != 0) begin
          resp_t r;
          r = rd_pend.pop_front();
          r.cmd[22] = s2mm_last;
          r.data    = s2mm_data;
          resp_q.push_back(r);
        end
      end
      if (umi_out_valid && umi_out_ready) begin
        chk("resp_expected", resp_q.size() != 0, 1'b1);
        if (resp_q.size() != 0) begin
          chk("resp_cmd", umi_out_cmd, resp_q[0].cmd);
          chk("resp_dst", umi_out_dstaddr, resp_q[0].dst);
          chk("resp_src", umi_out_srcaddr, resp_q[0].src);
          chk("resp_data", umi_out_data, resp_q[0].data);
          void'(resp_q.pop_front());
        end
      end
      if (umi_in_valid && umi_in_ready) begin
        logic [4:0] op;
        resp_t      r;
        op    = umi_in_cmd[4:0];
        r.dst = umi_in_srcaddr;
        r.src = umi_in_dstaddr;
        r.data = '0;
        if (op == 5'h05) begin
          beat_q.push_back({umi_in_cmd[22], umi_in_data});
        end else if (op == 5'h03) begin
          beat_q.push_back({umi_in_cmd[22], umi_in_data});
          r.cmd = mk_cmd(5'h04, umi_in_cmd[7:5], umi_in_cmd[15:8], umi_in_cmd[22], 2'b00);
          resp_q.push_back(r);
        end else if (op == 5'h01 && devicemode) begin
          r.cmd = mk_cmd(5'h02, umi_in_cmd[7:5], umi_in_cmd[15:8], 1'b0, 2'b00);
          rd_pend.push_back(r);
        end else begin
          err_exp = 1'b1;
          if (op == 5'h01) begin
            r.cmd = mk_cmd(5'h02, umi_in_cmd[7:5], umi_in_cmd[15:8], umi_in_cmd[22], 2'b10);
            resp_q.push_back(r);
          end
        end
      end
      p_mv = mm2s_valid; p_mr = mm2s_ready; p_mdata = mm2s_data; p_mlast = mm2s_last;
      p_ov = umi_out_valid; p_or = umi_out_ready; p_ocmd = umi_out_cmd;
      p_odst = umi_out_dstaddr; p_osrc = umi_out_srcaddr; p_odata = umi_out_data;
    end
  end

  task automatic step();
    @(posedge umi_clk);
    #1;
  endtask

  // Present one request and return just after the edge that captured it.
  task automatic send_req(input logic [CW-1:0] c, input logic [AW-1:0] d,
                          input logic [AW-1:0] s, input logic [DW-1:0] dat);
    int n = 0;
    umi_in_valid = 1'b1; umi_in_cmd = c; umi_in_dstaddr = d;
    umi_in_srcaddr = s; umi_in_data = dat;
    @(negedge umi_clk);
    while (!umi_in_ready && n < 50) begin
      @(negedge umi_clk);
      n++;
    end
    n_checks++;
    if (!umi_in_ready) begin
      n_errors++;
      $display("FAIL req_accept_timeout: umi_in_ready got 0, required 1 within 50 cycles");
    end
    step();
    umi_in_valid = 1'b0;
  endtask

  logic [DW-1:0] pat_a5, pat_wr, pat_rs;

  initial begin
    pat_a5 = {8{32'hA5A5A5A5}};
    pat_wr = {8{32'h0BADF00D}};
    pat_rs = {8{32'h5A5A5A5A}};
    umi_nreset = 1'b0; devicemode = 1'b1; umi_in_valid = 1'b0; umi_in_cmd = '0;
    umi_in_dstaddr = '0; umi_in_srcaddr = '0; umi_in_data = '0; umi_out_ready = 1'b1;
    mm2s_ready = 1'b1; s2mm_valid = 1'b0; s2mm_data = '0; s2mm_last = 1'b0;

    repeat (2) @(negedge umi_clk);
    chk("rst_in_ready", umi_in_ready, 1'b0);
    chk("rst_out_valid", umi_out_valid, 1'b0);
    chk("rst_mm2s_valid", mm2s_valid, 1'b0);
    chk("rst_s2mm_ready", s2mm_ready, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    #2 umi_nreset = 1'b1;
    #1 chk("release_in_ready_low", umi_in_ready, 1'b0);
    step();
    chk("release_in_ready_high", umi_in_ready, 1'b1);

    // Posted write: one beat with last=1, no response, 2-cycle turnaround.
    send_req(mk_cmd(5'h05, 3'd5, 8'd0, 1'b1, 2'b00), 64'h100, 64'h200, pat_a5);
    @(negedge umi_clk);
    chk("posted_mm2s_valid", mm2s_valid, 1'b1);
    chk("posted_mm2s_last", mm2s_last, 1'b1);
    chk("posted_mm2s_data", mm2s_data, pat_a5);
    chk("posted_no_resp", umi_out_valid, 1'b0);
    chk("posted_busy", umi_in_ready, 1'b0);
    @(negedge umi_clk);
    chk("posted_back_idle", umi_in_ready, 1'b1);
    chk("posted_one_beat", mm2s_valid, 1'b0);
    step();

    // Acked write with mm2s stalled 5 cycles.
    mm2s_ready = 1'b0;
    send_req(mk_cmd(5'h03, 3'd2, 8'd3, 1'b1, 2'b00), 64'h1000, 64'h2000, pat_wr);
    for (int i = 0; i < 5; i++) begin
      @(negedge umi_clk);
      chk("write_stall_valid", mm2s_valid, 1'b1);
      chk("write_stall_data", mm2s_data, pat_wr);
    end
    step();
    mm2s_ready = 1'b1;
    @(negedge umi_clk);
    chk("write_push", mm2s_valid, 1'b1);
    step();
    @(negedge umi_clk);
    chk("ack_valid", umi_out_valid, 1'b1);
    chk("ack_cmd", umi_out_cmd, 32'h0040_0344);
    chk("ack_dst", umi_out_dstaddr, 64'h2000);
    chk("ack_src", umi_out_srcaddr, 64'h1000);
    step();
    @(negedge umi_clk);
    chk("ack_back_idle", umi_in_ready, 1'b1);
    step();

    // Device read, data arrives late; devicemode flips mid-flight.
    s2mm_valid = 1'b0;
    send_req(mk_cmd(5'h01, 3'd5, 8'd0, 1'b0, 2'b00), 64'h3000, 64'h4000, '0);
    devicemode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge umi_clk);
      chk("read_wait_no_pop", s2mm_ready, 1'b0);
    end
    step();
    s2mm_valid = 1'b1; s2mm_data = 256'h1234; s2mm_last = 1'b1;
    @(negedge umi_clk);
    chk("read_pop", s2mm_ready, 1'b1);
    step();
    s2mm_data = 256'h9999;
    @(negedge umi_clk);
    chk("read_single_pulse", s2mm_ready, 1'b0);
    chk("read_resp_valid", umi_out_valid, 1'b1);
    chk("read_resp_cmd", umi_out_cmd, 32'h0040_00A2);
    chk("read_resp_data", umi_out_data, 256'h1234);
    chk("read_resp_dst", umi_out_dstaddr, 64'h4000);
    chk("read_resp_src", umi_out_srcaddr, 64'h3000);
    step();
    s2mm_valid = 1'b0; devicemode = 1'b1;
    @(negedge umi_clk);
    chk("read_back_idle", umi_in_ready, 1'b1);
    step();

    // Read with response back-pressured 8 cycles.
    s2mm_valid = 1'b1; s2mm_data = 256'hBEEF; s2mm_last = 1'b0; umi_out_ready = 1'b0;
    send_req(mk_cmd(5'h01, 3'd0, 8'd0, 1'b1, 2'b00), 64'h7000, 64'h8000, '0);
    @(negedge umi_clk);
    chk("bp_pop", s2mm_ready, 1'b1);
    step();
    s2mm_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge umi_clk);
      chk("bp_out_valid", umi_out_valid, 1'b1);
      chk("bp_in_ready_low", umi_in_ready, 1'b0);
      chk("bp_data", umi_out_data, 256'hBEEF);
    end
    step();
    umi_out_ready = 1'b1;
    @(negedge umi_clk);
    chk("bp_resp_cmd", umi_out_cmd, 32'h0000_0002);
    step();

    // Link-mode read is illegal: DEVERR read response, sticky flag.
    @(negedge umi_clk);
    chk("err_flag_clear", err_flag, 1'b0);
    step();
    devicemode = 1'b0;
    send_req(mk_cmd(5'h01, 3'd5, 8'd1, 1'b1, 2'b00), 64'h5000, 64'h6000, {8{32'hFFFFFFFF}});
    @(negedge umi_clk);
    chk("err_flag_set", err_flag, 1'b1);
    chk("err_resp_valid", umi_out_valid, 1'b1);
    chk("err_resp_cmd", umi_out_cmd, 32'h0440_01A2);
    chk("err_resp_data", umi_out_data, '0);
    chk("err_resp_dst", umi_out_dstaddr, 64'h6000);
    step();
    devicemode = 1'b1;

    // Unknown opcode: dropped in one cycle, no response.
    send_req(mk_cmd(5'h0F, 3'd0, 8'd0, 1'b0, 2'b00), 64'h9, 64'hA, '0);
    @(negedge umi_clk);
    chk("illegal_no_resp", umi_out_valid, 1'b0);
    chk("illegal_no_push", mm2s_valid, 1'b0);
    chk("illegal_busy", umi_in_ready, 1'b0);
    @(negedge umi_clk);
    chk("illegal_back_idle", umi_in_ready, 1'b1);
    chk("err_flag_sticky", err_flag, 1'b1);
    step();

    // Reset during a stalled push.
    mm2s_ready = 1'b0;
    send_req(mk_cmd(5'h03, 3'd0, 8'd0, 1'b1, 2'b00), 64'hA, 64'hB, pat_rs);
    @(negedge umi_clk);
    chk("rst_mid_push_valid", mm2s_valid, 1'b1);
    #2 umi_nreset = 1'b0;
    #1;
    chk("rst_mid_mm2s_valid", mm2s_valid, 1'b0);
    chk("rst_mid_out_valid", umi_out_valid, 1'b0);
    chk("rst_mid_s2mm_ready", s2mm_ready, 1'b0);
    chk("rst_mid_err_flag", err_flag, 1'b0);
    chk("rst_mid_in_ready", umi_in_ready, 1'b0);
    chk("rst_mid_data_cleared", mm2s_data, '0);
    mm2s_ready = 1'b1;
    @(posedge umi_clk);
    @(negedge umi_clk);
    #2 umi_nreset = 1'b1;
    step();
    chk("rst_mid_idle", umi_in_ready, 1'b1);
    chk("rst_mid_no_push", mm2s_valid, 1'b0);

    send_req(mk_cmd(5'h05, 3'd0, 8'd0, 1'b0, 2'b00), 64'h1, 64'h2, 256'h77);
    @(negedge umi_clk);
    chk("post_rst_push", mm2s_valid, 1'b1);
    chk("post_rst_last", mm2s_last, 1'b0);
    step();
    @(negedge umi_clk);
    chk("model_beats_drained", beat_q.size(), 0);
    chk("model_resps_drained", resp_q.size(), 0);
    chk("model_reads_drained", rd_pend.size(), 0);
`ifdef UMI_STREAM_CTRL_STATS_EN
    chk("stat_push", stat_push, 32'd1);
    chk("stat_pop", stat_pop, 32'd0);
    chk("stat_err", stat_err, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
